// File: rtl/mem_ctrl.sv
// Byte-serial RAM port arbiter for IF and MEM: splits 8/16/32-bit accesses into little-endian byte transfers.
// Optional one-entry fetch buffer compiled in with MEM_CTRL_FETCH_BUF_EN.
module mem_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic        if_done_out,
  output logic [31:0] if_data_out,
  input  logic        mem_req_in,
  input  logic        mem_we_in,
  input  logic [1:0]  mem_len_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] mem_wdata_in,
  output logic        mem_done_out,
  output logic [31:0] mem_rdata_out,
  output logic [31:0] ram_addr_out,
  output logic        ram_we_out,
  output logic [7:0]  ram_wdata_out,
  input  logic [7:0]  ram_rdata_in
);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  // Index of the last byte for a length code: 1, 2 or 4 bytes.
  function automatic logic [1:0] last_idx(input logic [1:0] len);
    logic [1:0] l;
    case (len)
      2'b00:   l = 2'd0;
      2'b01:   l = 2'd1;
      default: l = 2'd3;
    endcase
    return l;
  endfunction

  state_t      state_q, state_d;
  logic        owner_q, owner_d;   // 1 = MEM, 0 = IF
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic        ram_we_q, ram_we_d;
  logic [7:0]  ram_wdata_q, ram_wdata_d;
  logic        if_done_q, if_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic        mem_done_q, mem_done_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic [1:0]  k_next_s;
  logic        fb_hit_s;
  logic [31:0] fb_data_s;

`ifdef MEM_CTRL_FETCH_BUF_EN
  logic        fb_valid_q, fb_valid_d;
  logic [31:0] fb_addr_q, fb_addr_d;
  logic [31:0] fb_data_q, fb_data_d;

  assign fb_hit_s  = fb_valid_q && (fb_addr_q == if_addr_in);
  assign fb_data_s = fb_data_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      fb_valid_q <= 1'b0;
      fb_addr_q  <= 32'd0;
      fb_data_q  <= 32'd0;
    end else begin
      fb_valid_q <= fb_valid_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
    end
  end
`else
  assign fb_hit_s  = 1'b0;
  assign fb_data_s = 32'd0;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A fetch-buffer hit skips the RAM and reports straight from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_req_in) begin
          state_d = XFER;
        end else if (if_req_in) begin
          state_d = fb_hit_s ? DONE : XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (k_q == last_q) begin
          state_d = we_q ? DONE : WAIT;
        end else begin
          state_d = XFER;
        end
      end
      WAIT:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    last_d      = last_q;
    k_d         = k_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = ram_we_q;
    ram_wdata_d = ram_wdata_q;
    if_done_d   = 1'b0;
    if_data_d   = if_data_q;
    mem_done_d  = 1'b0;
    mem_rdata_d = mem_rdata_q;
    k_next_s    = k_q + 2'd1;
`ifdef MEM_CTRL_FETCH_BUF_EN
    fb_valid_d  = fb_valid_q;
    fb_addr_d   = fb_addr_q;
    fb_data_d   = fb_data_q;
`endif
    case (state_q)
      IDLE: begin
        if (mem_req_in) begin
          owner_d     = 1'b1;
          addr_d      = mem_addr_in;
          we_d        = mem_we_in;
          last_d      = last_idx(mem_len_in);
          k_d         = 2'd0;
          wdata_d     = mem_wdata_in;
          rdata_d     = 32'd0;
          ram_addr_d  = mem_addr_in;
          ram_we_d    = mem_we_in;
          ram_wdata_d = mem_wdata_in[7:0];
        end else if (if_req_in) begin
          if (fb_hit_s) begin
            if_done_d = 1'b1;
            if_data_d = fb_data_s;
          end else begin
            owner_d     = 1'b0;
            addr_d      = if_addr_in;
            we_d        = 1'b0;
            last_d      = 2'd3;
            k_d         = 2'd0;
            wdata_d     = 32'd0;
            rdata_d     = 32'd0;
            ram_addr_d  = if_addr_in;
            ram_we_d    = 1'b0;
            ram_wdata_d = 8'd0;
          end
        end else begin
          k_d = k_q;
        end
      end
      XFER: begin
        // The byte addressed in the previous cycle arrives now.
        if (!we_q && (k_q != 2'd0)) begin
          rdata_d = put_byte(rdata_q, k_q - 2'd1, ram_rdata_in);
        end else begin
          rdata_d = rdata_q;
        end
        if (k_q == last_q) begin
          if (we_q) begin
            ram_we_d = 1'b0;
            if (owner_q) begin
              mem_done_d = 1'b1;
            end else begin
              if_done_d = 1'b1;
            end
`ifdef MEM_CTRL_FETCH_BUF_EN
            fb_valid_d = 1'b0;
`endif
          end else begin
            ram_addr_d = ram_addr_q;
          end
        end else begin
          k_d         = k_next_s;
          ram_addr_d  = addr_q + {30'd0, k_next_s};
          ram_wdata_d = get_byte(wdata_q, k_next_s);
        end
      end
      WAIT: begin
        rdata_d = put_byte(rdata_q, last_q, ram_rdata_in);
        if (owner_q) begin
          mem_done_d  = 1'b1;
          mem_rdata_d = rdata_d;
        end else begin
          if_done_d = 1'b1;
          if_data_d = rdata_d;
`ifdef MEM_CTRL_FETCH_BUF_EN
          fb_valid_d = 1'b1;
          fb_addr_d  = addr_q;
          fb_data_d  = rdata_d;
`endif
        end
      end
      DONE:    k_d = k_q;
      default: k_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      owner_q     <= 1'b0;
      addr_q      <= 32'd0;
      we_q        <= 1'b0;
      last_q      <= 2'd0;
      k_q         <= 2'd0;
      wdata_q     <= 32'd0;
      rdata_q     <= 32'd0;
      ram_addr_q  <= 32'd0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= 8'd0;
      if_done_q   <= 1'b0;
      if_data_q   <= 32'd0;
      mem_done_q  <= 1'b0;
      mem_rdata_q <= 32'd0;
    end else begin
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      last_q      <= last_d;
      k_q         <= k_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      if_done_q   <= if_done_d;
      if_data_q   <= if_data_d;
      mem_done_q  <= mem_done_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign if_done_out   = if_done_q;
  assign if_data_out   = if_data_q;
  assign mem_done_out  = mem_done_q;
  assign mem_rdata_out = mem_rdata_q;
  assign ram_addr_out  = ram_addr_q;
  assign ram_we_out    = ram_we_q;
  assign ram_wdata_out = ram_wdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-wide RAM model with 1-cycle read latency, cycle-exact checks.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        if_req_in = 1'b0;
  logic [31:0] if_addr_in = 32'd0;
  logic        if_done_out;
  logic [31:0] if_data_out;
  logic        mem_req_in = 1'b0;
  logic        mem_we_in = 1'b0;
  logic [1:0]  mem_len_in = 2'b00;
  logic [31:0] mem_addr_in = 32'd0;
  logic [31:0] mem_wdata_in = 32'd0;
  logic        mem_done_out;
  logic [31:0] mem_rdata_out;
  logic [31:0] ram_addr_out;
  logic        ram_we_out;
  logic [7:0]  ram_wdata_out;
  logic [7:0]  ram_rdata_in = 8'd0;

  logic [7:0]  ram [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = 16'd0;
  logic [7:0]  pl_data = 8'd0;

  int n_checks = 0;
  int n_errors = 0;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in),
    .if_done_out(if_done_out), .if_data_out(if_data_out),
    .mem_req_in(mem_req_in), .mem_we_in(mem_we_in), .mem_len_in(mem_len_in),
    .mem_addr_in(mem_addr_in), .mem_wdata_in(mem_wdata_in),
    .mem_done_out(mem_done_out), .mem_rdata_out(mem_rdata_out),
    .ram_addr_out(ram_addr_out), .ram_we_out(ram_we_out),
    .ram_wdata_out(ram_wdata_out), .ram_rdata_in(ram_rdata_in)
  );

  always #5 clk_in = ~clk_in;

  // RAM model: 64 KiB image (address wraps on the low 16 bits), read data one cycle late.
  always @(posedge clk_in) begin
    if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (ram_we_out) begin
      ram[ram_addr_out[15:0]] <= ram_wdata_out;
    end
    ram_rdata_in <= ram[ram_addr_out[15:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Issues one request from the IDLE negedge and checks the cycle of its done pulse.
  task automatic access(input string tag, input bit is_mem, input bit we, input logic [1:0] len,
                        input logic [31:0] addr, input logic [31:0] wdata, input int exp_cyc,
                        input logic [31:0] exp_data, input bit chk_data);
    int got;
    bit seen;
    got  = 0;
    seen = 1'b0;
    @(negedge clk_in);
    if (is_mem) begin
      mem_req_in   = 1'b1;
      mem_we_in    = we;
      mem_len_in   = len;
      mem_addr_in  = addr;
      mem_wdata_in = wdata;
    end else begin
      if_req_in  = 1'b1;
      if_addr_in = addr;
    end
    @(posedge clk_in);
    for (int c = 1; c <= 12 && !seen; c++) begin
      @(negedge clk_in);
      if (is_mem ? mem_done_out : if_done_out) begin
        seen = 1'b1;
        got  = c;
      end
    end
    check({tag, "_cyc"}, got, exp_cyc);
    if (chk_data) begin
      check({tag, "_data"}, is_mem ? mem_rdata_out : if_data_out, exp_data);
    end
    mem_req_in = 1'b0;
    mem_we_in  = 1'b0;
    if_req_in  = 1'b0;
  endtask

  logic [15:0] pre_a [12] = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h0010, 16'h0011,
                              16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'hFFFE, 16'hFFFF};
  logic [7:0]  pre_d [12] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h34, 8'h12,
                              8'h11, 8'h22, 8'h33, 8'h44, 8'hA1, 8'hB2};
  logic [31:0] wrap_a [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
  logic        quiet;

  initial begin
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_in);
      pl_en   = 1'b1;
      pl_addr = pre_a[i];
      pl_data = pre_d[i];
    end
    @(negedge clk_in);
    pl_en = 1'b0;

    check("rst_ram_addr", ram_addr_out, 32'd0);
    check("rst_ram_we", {31'd0, ram_we_out}, 32'd0);
    check("rst_ram_wdata", {24'd0, ram_wdata_out}, 32'd0);
    check("rst_if_done", {31'd0, if_done_out}, 32'd0);
    check("rst_if_data", if_data_out, 32'd0);
    check("rst_mem_done", {31'd0, mem_done_out}, 32'd0);
    check("rst_mem_rdata", mem_rdata_out, 32'd0);
    rst_in = 1'b1;

    // IF word fetch of 0x1000
    @(negedge clk_in);
    if_req_in  = 1'b1;
    if_addr_in = 32'h0000_1000;
    @(posedge clk_in);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_in);
      if (c <= 4) begin
        check("if_ram_addr", ram_addr_out, 32'h0000_1000 + 32'(c - 1));
        check("if_ram_we", {31'd0, ram_we_out}, 32'd0);
      end
      check("if_done", {31'd0, if_done_out}, (c == 6) ? 32'd1 : 32'd0);
    end
    check("if_data", if_data_out, 32'h0010_0513);
    if_req_in = 1'b0;

    // MEM byte store to 0x2003
    @(negedge clk_in);
    check("if_pulse_once", {31'd0, if_done_out}, 32'd0);
    mem_req_in   = 1'b1;
    mem_we_in    = 1'b1;
    mem_len_in   = 2'b00;
    mem_addr_in  = 32'h0000_2003;
    mem_wdata_in = 32'hAABB_CCDD;
    @(posedge clk_in);
    @(negedge clk_in);
    check("st_we", {31'd0, ram_we_out}, 32'd1);
    check("st_addr", ram_addr_out, 32'h0000_2003);
    check("st_wdata", {24'd0, ram_wdata_out}, 32'h0000_00DD);
    check("st_early_done", {31'd0, mem_done_out}, 32'd0);
    @(negedge clk_in);
    check("st_done", {31'd0, mem_done_out}, 32'd1);
    check("st_we_off", {31'd0, ram_we_out}, 32'd0);
    mem_req_in = 1'b0;
    mem_we_in  = 1'b0;

    // Simultaneous IF word fetch at 0x0 and MEM half load at 0x10
    @(negedge clk_in);
    if_req_in   = 1'b1;
    if_addr_in  = 32'h0000_0000;
    mem_req_in  = 1'b1;
    mem_we_in   = 1'b0;
    mem_len_in  = 2'b01;
    mem_addr_in = 32'h0000_0010;
    @(posedge clk_in);
    @(negedge clk_in);
    check("sim_addr1", ram_addr_out, 32'h0000_0010);
    @(negedge clk_in);
    check("sim_addr2", ram_addr_out, 32'h0000_0011);
    @(negedge clk_in);
    check("sim_c3_done", {31'd0, mem_done_out}, 32'd0);
    @(negedge clk_in);
    check("sim_mem_done", {31'd0, mem_done_out}, 32'd1);
    check("sim_mem_rdata", mem_rdata_out, 32'h0000_1234);
    check("sim_if_wait", {31'd0, if_done_out}, 32'd0);
    mem_req_in = 1'b0;
    @(negedge clk_in);
    check("sim_c5_hold", ram_addr_out, 32'h0000_0011);
    @(negedge clk_in);
    check("sim_if_grant", ram_addr_out, 32'h0000_0000);
    for (int c = 7; c <= 11; c++) begin
      @(negedge clk_in);
    end
    check("sim_if_done", {31'd0, if_done_out}, 32'd1);
    check("sim_if_data", if_data_out, 32'h4433_2211);
    if_req_in = 1'b0;

    // Word load wrapping around the top of the address space
    @(negedge clk_in);
    mem_req_in  = 1'b1;
    mem_we_in   = 1'b0;
    mem_len_in  = 2'b10;
    mem_addr_in = 32'hFFFF_FFFE;
    @(posedge clk_in);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_in);
      if (c <= 4) begin
        check("wrap_addr", ram_addr_out, wrap_a[c - 1]);
      end
    end
    check("wrap_done", {31'd0, mem_done_out}, 32'd1);
    check("wrap_data", mem_rdata_out, 32'h2211_B2A1);
    mem_req_in = 1'b0;

    // Reset in cycle 2 of a word store
    @(negedge clk_in);
    mem_req_in   = 1'b1;
    mem_we_in    = 1'b1;
    mem_len_in   = 2'b10;
    mem_addr_in  = 32'h0000_3000;
    mem_wdata_in = 32'h0102_0304;
    @(posedge clk_in);
    @(negedge clk_in);
    check("rs_wdata1", {24'd0, ram_wdata_out}, 32'h0000_0004);
    @(negedge clk_in);
    check("rs_we_c2", {31'd0, ram_we_out}, 32'd1);
    check("rs_addr_c2", ram_addr_out, 32'h0000_3001);
    rst_in = 1'b0;
    #1;
    check("rs_we_drop", {31'd0, ram_we_out}, 32'd0);
    check("rs_mem_done", {31'd0, mem_done_out}, 32'd0);
    check("rs_mem_rdata", mem_rdata_out, 32'd0);
    mem_req_in = 1'b0;
    mem_we_in  = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    quiet  = 1'b0;
    repeat (8) begin
      @(negedge clk_in);
      quiet = quiet | mem_done_out | if_done_out;
    end
    check("rs_no_done", {31'd0, quiet}, 32'd0);
    access("post_rst_ld", 1'b1, 1'b0, 2'b00, 32'h0000_1000, 32'd0, 3, 32'h0000_0013, 1'b1);

    // Repeated fetch, then a store that must invalidate any buffered word
    access("if_fill", 1'b0, 1'b0, 2'b10, 32'h0000_1000, 32'd0, 6, 32'h0010_0513, 1'b1);
`ifdef MEM_CTRL_FETCH_BUF_EN
    access("if_hit", 1'b0, 1'b0, 2'b10, 32'h0000_1000, 32'd0, 1, 32'h0010_0513, 1'b1);
    check("hit_no_ram", ram_addr_out, 32'h0000_1003);
`else
    access("if_refetch", 1'b0, 1'b0, 2'b10, 32'h0000_1000, 32'd0, 6, 32'h0010_0513, 1'b1);
`endif
    access("st_1001", 1'b1, 1'b1, 2'b00, 32'h0000_1001, 32'h0000_0077, 2, 32'd0, 1'b0);
    access("if_after_st", 1'b0, 1'b0, 2'b10, 32'h0000_1000, 32'd0, 6, 32'h0010_7713, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
